boot_sequencer: RTL

//  Power-on sequencer between reset and the RI5CY wrapper. It launches the memory

---
 rtl/boot_sequencer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/boot_sequencer.sv
// -----------------------------------------------------------------------------
// boot_sequencer
//
// Power-on sequencer that sits between reset and the RI5CY wrapper. After
// reset it:
//   1. launches the memory BIST and checks its go/no-go verdict
//      (this step is skipped when bypass_bist_i is set),
//   2. requests the firmware image load into DRAM,
//   3. holds the core in reset for RESET_HOLD cycles,
//   4. releases the core and raises fetch enable one cycle later.
// A timeout guards each wait on an external agent. Any failure parks the
// sequencer in FAIL with a sticky error code.
//
// Ports
//   clk             in   clock
//   rst_n           in   asynchronous, active-low reset
//   start_i         in   level; the sequence starts when it is sampled 1 in IDLE
//   bypass_bist_i   in   sampled with start_i; 1 = skip BIST and go to LOAD
//   bist_start_o    out  one-cycle pulse that launches the BIST
//   bist_done_i     in   one-cycle pulse; the BIST has finished
//   bist_pass_i     in   BIST verdict; valid only while bist_done_i=1
//   load_req_o      out  level; firmware load requested
//   load_ack_i      in   load complete; sampled only while load_req_o=1
//   core_rst_no     out  active-low reset to the core
//   fetch_enable_o  out  core fetch enable
//   pass_o          out  sticky; the sequence completed
//   fail_o          out  sticky; the sequence aborted
//   err_code_o      out  0 none, 1 BIST fail, 2 BIST timeout, 3 load timeout
//   state_o         out  current FSM state (IDLE=0 .. FAIL=5)
//
// Handshakes
//   BIST: bist_start_o pulses once in the first BIST_RUN cycle. A bist_done_i
//   pulse in any BIST_RUN cycle, including the entry cycle, ends the wait,
//   and bist_pass_i is read in that same cycle. Outside BIST_RUN the sequencer
//   ignores bist_done_i.
//   LOAD: load_req_o is held high from the first LOAD cycle to the cycle in
//   which load_ack_i is sampled high. It drops on the following cycle.
//   Outside LOAD the sequencer ignores load_ack_i.
//
// Every output is taken straight from a flop. state_o is the state register
// itself.
// -----------------------------------------------------------------------------
module boot_sequencer #(
    parameter int BIST_TIMEOUT = 4096,   // max cycles in BIST_RUN (>=2)
    parameter int LOAD_TIMEOUT = 65536,  // max cycles in LOAD (>=2)
    parameter int RESET_HOLD   = 4,      // core reset hold cycles (>=1)
    parameter int CNT_W        = 17      // holds max(BIST_TIMEOUT, LOAD_TIMEOUT)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       bypass_bist_i,
    output logic       bist_start_o,
    input  logic       bist_done_i,
    input  logic       bist_pass_i,
    output logic       load_req_o,
    input  logic       load_ack_i,
    output logic       core_rst_no,
    output logic       fetch_enable_o,
    output logic       pass_o,
    output logic       fail_o,
    output logic [1:0] err_code_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_BIST_RUN = 3'd1,
        S_LOAD     = 3'd2,
        S_RELEASE  = 3'd3,
        S_RUN      = 3'd4,
        S_FAIL     = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_BIST_FAIL = 2'd1;
    localparam logic [1:0] ERR_BIST_TO   = 2'd2;
    localparam logic [1:0] ERR_LOAD_TO   = 2'd3;

    // Each terminal count is reached in the Nth cycle of its state. The
    // counter reads 0 in the state's entry cycle.
    localparam logic [CNT_W-1:0] BIST_LAST = CNT_W'(BIST_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t           state;
    logic [CNT_W-1:0] cnt;

    assign state_o = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            cnt            <= '0;
            bist_start_o   <= 1'b0;
            load_req_o     <= 1'b0;
            core_rst_no    <= 1'b0;
            fetch_enable_o <= 1'b0;
            pass_o         <= 1'b0;
            fail_o         <= 1'b0;
            err_code_o     <= ERR_NONE;
        end else begin
            // Default: the counter saturates and never wraps. Every state
            // entry below overrides this with a clear.
            if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            // The BIST launch is a single-cycle pulse. It is set only on
            // entry to BIST_RUN.
            bist_start_o <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        cnt <= '0;
                        if (bypass_bist_i) begin
                            state      <= S_LOAD;
                            load_req_o <= 1'b1;
                        end else begin
                            state        <= S_BIST_RUN;
                            bist_start_o <= 1'b1;
                        end
                    end
                end

                S_BIST_RUN: begin
                    // A done pulse is checked before the timeout, so done
                    // wins when both land in the same cycle.
                    if (bist_done_i) begin
                        cnt <= '0;
                        if (bist_pass_i) begin
                            state      <= S_LOAD;
                            load_req_o <= 1'b1;
                        end else begin
                            state      <= S_FAIL;
                            fail_o     <= 1'b1;
                            err_code_o <= ERR_BIST_FAIL;
                        end
                    end else if (cnt == BIST_LAST) begin
                        cnt        <= '0;
                        state      <= S_FAIL;
                        fail_o     <= 1'b1;
                        err_code_o <= ERR_BIST_TO;
                    end
                end

                S_LOAD: begin
                    // The ack is checked before the timeout, so ack wins
                    // when both land in the same cycle.
                    if (load_ack_i) begin
                        cnt        <= '0;
                        state      <= S_RELEASE;
                        load_req_o <= 1'b0;
                    end else if (cnt == LOAD_LAST) begin
                        cnt        <= '0;
                        state      <= S_FAIL;
                        load_req_o <= 1'b0;
                        fail_o     <= 1'b1;
                        err_code_o <= ERR_LOAD_TO;
                    end
                end

                S_RELEASE: begin
                    // core_rst_no is already low. It stays low through
                    // counter values 0 .. RESET_HOLD-1.
                    if (cnt == HOLD_LAST) begin
                        cnt         <= '0;
                        state       <= S_RUN;
                        core_rst_no <= 1'b1;
                        pass_o      <= 1'b1;
                    end
                end

                S_RUN: begin
                    // Fetch enable follows the core reset release by one
                    // cycle. RUN is terminal until rst_n.
                    fetch_enable_o <= 1'b1;
                end

                S_FAIL: begin
                    // Terminal until rst_n. The core is kept parked and
                    // err_code_o holds the value latched on entry.
                    core_rst_no    <= 1'b0;
                    fetch_enable_o <= 1'b0;
                    load_req_o     <= 1'b0;
                    fail_o         <= 1'b1;
                end

                default: begin
                    // Codes 6 and 7 are unreachable in normal operation.
                    // If one appears, park safely with no error code.
                    cnt            <= '0;
                    state          <= S_FAIL;
                    core_rst_no    <= 1'b0;
                    fetch_enable_o <= 1'b0;
                    load_req_o     <= 1'b0;
                    fail_o         <= 1'b1;
                    err_code_o     <= ERR_NONE;
                end
            endcase
        end
    end

endmodule
